// File: rtl/eth_buf_pkg.sv
// Shared constants and types for the Ethernet rx/tx buffer port-2 sequencer.
package eth_buf_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int RX_BASE_DEF = 0;
  localparam int RX_SIZE_DEF = 1024;
  localparam int TX_BASE_DEF = 1024;
  localparam int TX_SIZE_DEF = 1024;

  localparam logic [1:0] CSR_STATUS = 2'd0;
  localparam logic [1:0] CSR_RX_LEN = 2'd1;
  localparam logic [1:0] CSR_TX_LEN = 2'd2;
  localparam logic [1:0] CSR_CTRL   = 2'd3;

  localparam int ST_RX_FULL = 0;
  localparam int ST_TX_BUSY = 1;
  localparam int ST_RX_OVF  = 2;
  localparam int ST_RX_DROP = 3;
  localparam int ST_TX_DONE = 4;

  typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_RECV = 2'd1, RX_DROP = 2'd2} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_FETCH = 2'd1, TX_WAIT = 2'd2, TX_OUT = 2'd3} tx_state_t;

  function automatic logic [31:0] sat_len(input logic [31:0] v, input logic [31:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/eth_buf_tx_fetch.sv
// TX sequencer: fetches one byte per FETCH/WAIT pair from the TX region and
// holds it on the MAC interface until the ready/valid handshake completes.
module eth_buf_tx_fetch
  import eth_buf_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TX_BASE = TX_BASE_DEF,
  parameter int TX_SIZE = TX_SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] tx_len,
  input  logic              port_free,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        buf_readdata,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);
  localparam logic [ADDR_W-1:0] TX_SIZE_A = ADDR_W'(TX_SIZE);

  tx_state_t         state;
  logic [ADDR_W-1:0] idx;

  assign rd_req  = (state == TX_FETCH) && port_free;
  assign rd_addr = TX_BASE_A + (idx % TX_SIZE_A);

  // TX FSM with registered MAC-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      idx      <= {ADDR_W{1'b0}};
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            idx   <= {ADDR_W{1'b0}};
            state <= TX_FETCH;
          end
        end
        TX_FETCH: begin
          if (port_free) state <= TX_WAIT;
        end
        TX_WAIT: begin
          tx_data  <= buf_readdata;
          tx_valid <= 1'b1;
          tx_sop   <= (idx == {ADDR_W{1'b0}});
          tx_eop   <= (idx == tx_len - ADDR_W'(1));
          state    <= TX_OUT;
        end
        TX_OUT: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_sop   <= 1'b0;
            tx_eop   <= 1'b0;
            if (tx_eop) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= TX_IDLE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= TX_FETCH;
            end
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/eth_rxtx_buf_ctrl.sv
// Port-2 sequencer for the shared Ethernet buffer: RX FSM, RX-first port
// arbiter and the CPU-facing CSR block; the TX FSM lives in eth_buf_tx_fetch.
module eth_rxtx_buf_ctrl
  import eth_buf_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RX_BASE = RX_BASE_DEF,
  parameter int RX_SIZE = RX_SIZE_DEF,
  parameter int TX_BASE = TX_BASE_DEF,
  parameter int TX_SIZE = TX_SIZE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic              rx_err,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [ADDR_W-1:0] buf_address,
  output logic              buf_chipselect,
  output logic              buf_write,
  output logic [7:0]        buf_writedata,
  input  logic [7:0]        buf_readdata,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq
);
  localparam logic [ADDR_W-1:0] RX_BASE_A = ADDR_W'(RX_BASE);
  localparam logic [ADDR_W-1:0] RX_SIZE_A = ADDR_W'(RX_SIZE);

  rx_state_t         rx_state, rx_next;
  logic [ADDR_W-1:0] rx_cnt, cnt_next, wr_off, rx_len, tx_len, rd_addr;
  logic              rx_full, rx_ovf, rx_drop, tx_done;
  logic              rx_wr, set_full, set_ovf, set_drop;
  logic              tx_start, tx_busy, tx_fin, rd_req;
  logic              full_n, ovf_n, drop_n, done_n;
  logic [4:0]        w1c;
  logic [31:0]       status;

  // RX frame decode: decides the port-2 write and the next RX state
  always_comb begin
    rx_next  = rx_state;
    cnt_next = rx_cnt;
    wr_off   = rx_cnt;
    rx_wr    = 1'b0;
    set_full = 1'b0;
    set_ovf  = 1'b0;
    set_drop = 1'b0;
    if (rx_valid) begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_sop && rx_full) begin
            set_drop = 1'b1;
            rx_next  = rx_eop ? RX_IDLE : RX_DROP;
          end else if (rx_sop) begin
            rx_wr  = 1'b1;
            wr_off = {ADDR_W{1'b0}};
          end else begin
            rx_next = RX_IDLE;
          end
        end
        RX_RECV: begin
          if (rx_sop) begin
            rx_wr  = 1'b1;
            wr_off = {ADDR_W{1'b0}};
          end else if (rx_cnt == RX_SIZE_A) begin
            set_ovf = 1'b1;
            rx_next = rx_eop ? RX_IDLE : RX_DROP;
          end else begin
            rx_wr = 1'b1;
          end
        end
        RX_DROP: begin
          if (rx_eop) rx_next = RX_IDLE;
          else        rx_next = RX_DROP;
        end
        default: rx_next = RX_IDLE;
      endcase
      if (rx_wr) begin
        cnt_next = wr_off + ADDR_W'(1);
        if (rx_eop) begin
          rx_next  = RX_IDLE;
          set_full = !rx_err;
        end else begin
          rx_next = RX_RECV;
        end
      end else begin
        cnt_next = rx_cnt;
      end
    end else begin
      rx_next = rx_state;
    end
  end

  // RX state, byte count and committed frame length
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= {ADDR_W{1'b0}};
      rx_len   <= {ADDR_W{1'b0}};
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= cnt_next;
      if (set_full) rx_len <= cnt_next;
    end
  end

  // Port-2 mux: an RX byte always wins, a TX fetch waits for a free cycle
  always_comb begin
    buf_write      = 1'b0;
    buf_chipselect = 1'b0;
    buf_address    = {ADDR_W{1'b0}};
    buf_writedata  = 8'h00;
    if (reset) begin
      buf_chipselect = 1'b0;
    end else if (rx_wr) begin
      buf_write      = 1'b1;
      buf_chipselect = 1'b1;
      buf_address    = RX_BASE_A + (wr_off % RX_SIZE_A);
      buf_writedata  = rx_data;
    end else if (rd_req) begin
      buf_chipselect = 1'b1;
      buf_address    = rd_addr;
    end else begin
      buf_chipselect = 1'b0;
    end
  end

  eth_buf_tx_fetch #(.ADDR_W(ADDR_W), .TX_BASE(TX_BASE), .TX_SIZE(TX_SIZE)) u_tx (
    .clk          (clk),
    .reset        (reset),
    .start        (tx_start),
    .tx_len       (tx_len),
    .port_free    (!rx_wr),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .buf_readdata (buf_readdata),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_sop       (tx_sop),
    .tx_eop       (tx_eop),
    .busy         (tx_busy),
    .done         (tx_fin)
  );

  // A hardware set in the same cycle as a CPU clear leaves the bit set
  assign w1c      = (csr_write && csr_address == CSR_STATUS) ? csr_writedata[4:0] : 5'd0;
  assign full_n   = set_full | (rx_full & ~w1c[ST_RX_FULL]);
  assign ovf_n    = set_ovf  | (rx_ovf  & ~w1c[ST_RX_OVF]);
  assign drop_n   = set_drop | (rx_drop & ~w1c[ST_RX_DROP]);
  assign done_n   = tx_fin   | (tx_done & ~w1c[ST_TX_DONE]);
  assign tx_start = csr_write && (csr_address == CSR_CTRL) && csr_writedata[0]
                    && (tx_len != {ADDR_W{1'b0}}) && !tx_busy;

  // STATUS word as seen by the CPU
  always_comb begin
    status             = 32'd0;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_BUSY] = tx_busy;
    status[ST_RX_OVF]  = rx_ovf;
    status[ST_RX_DROP] = rx_drop;
    status[ST_TX_DONE] = tx_done;
  end

  // CSR registers, registered readback and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_full      <= 1'b0;
      rx_ovf       <= 1'b0;
      rx_drop      <= 1'b0;
      tx_done      <= 1'b0;
      tx_len       <= {ADDR_W{1'b0}};
      csr_readdata <= 32'd0;
      irq          <= 1'b0;
    end else begin
      rx_full <= full_n;
      rx_ovf  <= ovf_n;
      rx_drop <= drop_n;
      tx_done <= done_n;
      irq     <= full_n | done_n;
      if (csr_write && csr_address == CSR_TX_LEN && !tx_busy)
        tx_len <= ADDR_W'(sat_len(csr_writedata, 32'(TX_SIZE)));
      if (csr_read) begin
        case (csr_address)
          CSR_STATUS: csr_readdata <= status;
          CSR_RX_LEN: csr_readdata <= 32'(rx_len);
          CSR_TX_LEN: csr_readdata <= 32'(tx_len);
          CSR_CTRL:   csr_readdata <= 32'd0;
          default:    csr_readdata <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_rxtx_buf_ctrl.sv
// Directed bench for eth_rxtx_buf_ctrl with a behavioural 2048x8 port-2 RAM.
module tb_eth_rxtx_buf_ctrl;
  logic        clk = 1'b0;
  logic        reset, rx_valid, rx_sop, rx_eop, rx_err, tx_ready;
  logic [7:0]  rx_data, buf_readdata;
  logic        tx_valid, tx_sop, tx_eop, buf_chipselect, buf_write, irq;
  logic [7:0]  tx_data, buf_writedata;
  logic [10:0] buf_address;
  logic [1:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata, rd;

  int total = 0, bad = 0;
  int wr_cnt = 0, bad_wr = 0, bad_rd = 0;
  logic [7:0] mem [0:2047];
  logic [7:0] cap_d[$];
  int sop_mask, eop_mask, unstable;

  eth_rxtx_buf_ctrl dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .rx_err(rx_err), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .buf_address(buf_address),
    .buf_chipselect(buf_chipselect), .buf_write(buf_write), .buf_writedata(buf_writedata),
    .buf_readdata(buf_readdata), .csr_address(csr_address), .csr_read(csr_read),
    .csr_write(csr_write), .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] tx_pat(input logic [10:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // RAM model: registered address, TX region holds a fixed pattern
  always @(posedge clk) begin
    if (buf_chipselect && buf_write) begin
      mem[buf_address] <= buf_writedata;
      wr_cnt <= wr_cnt + 1;
      if (buf_address >= 11'd1024) bad_wr <= bad_wr + 1;
    end
    if (buf_chipselect && !buf_write) begin
      buf_readdata <= (buf_address >= 11'd1024) ? tx_pat(buf_address) : mem[buf_address];
      if (buf_address < 11'd1024) bad_rd <= bad_rd + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); csr_write = 1'b1; csr_address = a; csr_writedata = d;
    @(negedge clk); csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); csr_read = 1'b1; csr_address = a;
    @(negedge clk); csr_read = 1'b0; d = csr_readdata;
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input bit err);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = base + 8'(i);
      rx_sop = (i == 0); rx_eop = (i == len - 1); rx_err = err && (i == len - 1);
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
  endtask

  task automatic rx_mem_chk(input string tag, input int len, input logic [7:0] base);
    int errs = 0;
    for (int k = 0; k < len; k++)
      if (mem[k] !== base + 8'(k)) errs++;
    chk(tag, errs, 0);
  endtask

  // Drains n TX bytes; ready is decided and the byte captured at the same negedge
  task automatic tx_drain(input int n, input bit rnd, input int budget);
    int cyc = 0;
    logic hold = 1'b0, r;
    logic [7:0] hd = 8'h00;
    cap_d.delete(); sop_mask = 0; eop_mask = 0; unstable = 0;
    while (cap_d.size() < n && cyc < budget) begin
      @(negedge clk); cyc++;
      if (hold && (!tx_valid || tx_data !== hd)) unstable++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_ready = r;
      if (tx_valid && r) begin
        if (tx_sop) sop_mask |= (1 << cap_d.size());
        if (tx_eop) eop_mask |= (1 << cap_d.size());
        cap_d.push_back(tx_data);
      end
      hold = tx_valid && !r; hd = tx_data;
    end
    @(negedge clk); tx_ready = 1'b0;
  endtask

  task automatic tx_result(input string tag, input int n);
    int errs = 0;
    chk({tag, "_count"}, cap_d.size(), n);
    for (int k = 0; k < cap_d.size(); k++)
      if (cap_d[k] !== (8'(k) ^ 8'h5A)) errs++;
    chk({tag, "_data"}, errs, 0);
    chk({tag, "_sop"}, sop_mask, 1);
    chk({tag, "_eop"}, eop_mask, 1 << (n - 1));
    chk({tag, "_stable"}, unstable, 0);
  endtask

  initial begin
    int w0;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_sop = 1'b0; rx_eop = 1'b0;
    rx_err = 1'b0; tx_ready = 1'b0; csr_address = 2'd0; csr_read = 1'b0;
    csr_write = 1'b0; csr_writedata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_buf_cs", buf_chipselect, 0);
    chk("rst_csr_rd", csr_readdata, 0);
    reset = 1'b0;
    csr_rd(2'd0, rd); chk("rst_status", rd, 0);
    csr_rd(2'd1, rd); chk("rst_rx_len", rd, 0);
    csr_rd(2'd2, rd); chk("rst_tx_len", rd, 0);

    // good 64-byte frame
    w0 = wr_cnt;
    send_frame(64, 8'h00, 1'b0);
    chk("f64_writes", wr_cnt - w0, 64);
    rx_mem_chk("f64_data", 64, 8'h00);
    chk("f64_irq", irq, 1);
    csr_rd(2'd1, rd); chk("f64_rx_len", rd, 64);
    csr_rd(2'd0, rd); chk("f64_status", rd, 32'h1);

    // frame while full is dropped
    w0 = wr_cnt;
    send_frame(10, 8'h40, 1'b0);
    chk("drop_writes", wr_cnt - w0, 0);
    csr_rd(2'd0, rd); chk("drop_status", rd, 32'h9);
    csr_wr(2'd0, 32'h9);
    csr_rd(2'd0, rd); chk("w1c_status", rd, 0);
    chk("w1c_irq", irq, 0);

    // oversize frame
    w0 = wr_cnt;
    send_frame(1100, 8'h00, 1'b0);
    chk("ovf_writes", wr_cnt - w0, 1024);
    chk("ovf_last_byte", mem[1023], 8'hFF);
    csr_rd(2'd0, rd); chk("ovf_status", rd, 32'h4);
    csr_rd(2'd1, rd); chk("ovf_rx_len", rd, 64);
    csr_wr(2'd0, 32'h4);

    // errored frame leaves no trace in STATUS
    send_frame(8, 8'hC0, 1'b1);
    csr_rd(2'd0, rd); chk("err_status", rd, 0);
    chk("err_irq", irq, 0);

    // single-byte frame
    send_frame(1, 8'hE7, 1'b0);
    chk("one_data", mem[0], 8'hE7);
    csr_rd(2'd1, rd); chk("one_rx_len", rd, 1);
    csr_rd(2'd0, rd); chk("one_status", rd, 32'h1);
    csr_wr(2'd0, 32'h1);

    // TX length saturation, start, busy lockout, random backpressure
    csr_wr(2'd2, 32'd5000);
    csr_rd(2'd2, rd); chk("txlen_sat", rd, 1024);
    csr_wr(2'd2, 32'd5);
    csr_wr(2'd3, 32'h1);
    csr_rd(2'd0, rd); chk("tx_busy", rd, 32'h2);
    csr_wr(2'd2, 32'd7);
    csr_rd(2'd2, rd); chk("txlen_locked", rd, 5);
    tx_drain(5, 1'b1, 300);
    tx_result("tx5", 5);
    csr_rd(2'd0, rd); chk("tx5_status", rd, 32'h10);
    chk("tx5_irq", irq, 1);
    csr_wr(2'd0, 32'h10);

    // RX stream while TX runs
    csr_wr(2'd2, 32'd20);
    csr_wr(2'd3, 32'h1);
    w0 = wr_cnt;
    fork
      send_frame(40, 8'h80, 1'b0);
      tx_drain(20, 1'b0, 400);
    join
    chk("mix_writes", wr_cnt - w0, 40);
    rx_mem_chk("mix_rx_data", 40, 8'h80);
    tx_result("mix_tx", 20);
    csr_rd(2'd1, rd); chk("mix_rx_len", rd, 40);
    csr_rd(2'd0, rd); chk("mix_status", rd, 32'h11);
    chk("region_wr", bad_wr, 0);
    chk("region_rd", bad_rd, 0);
    csr_wr(2'd0, 32'h1F);

    // reset in the middle of a TX and an RX frame
    csr_wr(2'd2, 32'd100);
    csr_wr(2'd3, 32'h1);
    repeat (6) @(negedge clk);
    chk("mid_tx_valid", tx_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'(i); rx_sop = (i == 0); rx_eop = 1'b0;
    end
    #1;
    chk("mid_rx_write", buf_write, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("mrst_tx_valid", tx_valid, 0);
    chk("mrst_buf_write", buf_write, 0);
    chk("mrst_buf_cs", buf_chipselect, 0);
    chk("mrst_irq", irq, 0);
    rx_valid = 1'b0; rx_sop = 1'b0;
    reset = 1'b0;
    csr_rd(2'd0, rd); chk("mrst_status", rd, 0);
    csr_rd(2'd2, rd); chk("mrst_tx_len", rd, 0);
    csr_wr(2'd3, 32'h1);
    csr_rd(2'd0, rd); chk("start_len0_ignored", rd, 0);
    csr_wr(2'd2, 32'd3);
    csr_wr(2'd3, 32'h1);
    tx_drain(3, 1'b0, 100);
    tx_result("post_rst_tx", 3);
    csr_rd(2'd0, rd); chk("post_rst_status", rd, 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
